// File: rtl/mole_game_pkg.sv
// Shared types and helpers for the whack-a-mole game engine.
package mole_game_pkg;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_e;

  localparam int SCORE_REG_DEF = 30;

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/mole_game_engine_channel.sv
// One mole channel: button synchronizer, edge detect,
// lit/dark period counter and LED state.
module mole_channel #(
  parameter int CNT_W       = 28,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             btn,
  input  logic [CNT_W-1:0] on_ticks,
  input  logic [CNT_W-1:0] off_ticks,
  output logic             led,
  output logic             hit,
  output logic             timeout
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   led_q, led_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [CNT_W-1:0] on_lim, off_lim;
  logic             synced, rise, expire, relight;

  // A zero period behaves like a one-cycle period.
  assign on_lim  = (on_ticks == '0)  ? '0 : on_ticks - CNT_W'(1);
  assign off_lim = (off_ticks == '0) ? '0 : off_ticks - CNT_W'(1);

  assign synced  = sync_q[SYNC_STAGES-1];
  assign rise    = synced & ~prev_q;
  assign expire  = led_q & (cnt_q >= on_lim);
  assign relight = ~led_q & (cnt_q >= off_lim);

  assign led     = led_q;
  assign hit     = en & led_q & rise;
  assign timeout = en & expire & ~hit;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn};
    prev_d = synced;
    led_d  = led_q;
    cnt_d  = cnt_q;
    if (clear) begin
      led_d = 1'b1;
      cnt_d = '0;
    end else if (en) begin
      if (hit || expire) begin
        led_d = 1'b0;
        cnt_d = '0;
      end else if (relight) begin
        led_d = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      led_q  <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      led_q  <= led_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mole_game_engine.sv
// Whack-a-mole engine: pending score delta, register-file
// write slot, PLAY/OVER sequencing and restart handling.
module mole_game_engine
  import mole_game_pkg::*;
#(
  parameter int NUM_MOLES   = 4,
  parameter int CNT_W       = 28,
  parameter int SCORE_W     = 32,
  parameter int DELTA_W     = 8,
  parameter int WIN_SCORE   = 12,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 1000,
  parameter int SCORE_REG   = SCORE_REG_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_MOLES-1:0]       btn,
  input  logic                       restart_btn,
  input  logic [CNT_W-1:0]           on_ticks,
  input  logic [NUM_MOLES*CNT_W-1:0] off_ticks,
  input  logic [SCORE_W-1:0]         score_in,
  output logic [NUM_MOLES-1:0]       mole_led,
  output logic                       over_led,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [4:0]                 wr_reg,
  output logic [SCORE_W-1:0]         wr_data,
  output logic                       hit_pulse,
  output logic                       miss_pulse,
  output logic                       restart_pulse
);

  localparam int SW   = SCORE_W + 2;
  localparam int DW2  = DELTA_W + 2;
  localparam int HO_W = $clog2(HOLDOFF + 2);
  localparam logic signed [DW2-1:0] DMAX =
    DW2'(2 ** (DELTA_W - 1) - 1);
  localparam logic signed [DW2-1:0] DMIN = -DMAX;

  state_e                   state_q, state_d;
  logic signed [DELTA_W-1:0] delta_q, delta_d;
  logic                     gap_q, gap_d;
  logic [HO_W-1:0]          hold_q, hold_d;
  logic                     hit_p_q, hit_p_d;
  logic                     miss_p_q, miss_p_d;
  logic                     rst_p_q, rst_p_d;
  logic [SYNC_STAGES-1:0]   rsync_q, rsync_d;
  logic                     rprev_q, rprev_d;

  logic [NUM_MOLES-1:0] led_v, hit_v, tmo_v;
  logic                 play, xfer, rfall, restart_ok;
  logic [4:0]           hcnt, tcnt, grant;
  logic signed [SW-1:0] sum;
  logic signed [DW2-1:0] dnew, dsat;

  assign play = (state_q == PLAY);

  for (genvar g = 0; g < NUM_MOLES; g++) begin : g_ch
    mole_channel #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en       (play),
      .clear    (restart_ok),
      .btn      (btn[g]),
      .on_ticks (on_ticks),
      .off_ticks(off_ticks[g*CNT_W +: CNT_W]),
      .led      (led_v[g]),
      .hit      (hit_v[g]),
      .timeout  (tmo_v[g])
    );
  end

  assign sum      = $signed({2'b00, score_in}) + SW'(delta_q);
  assign wr_data  = sum[SW-1] ? '0 : sum[SCORE_W-1:0];
  assign wr_valid = play & (delta_q != '0) & ~gap_q & ~reset;
  assign xfer     = wr_valid & wr_ready;
  assign wr_reg   = 5'(SCORE_REG);

  assign mole_led      = play ? led_v : '0;
  assign over_led      = ~play;
  assign hit_pulse     = hit_p_q;
  assign miss_pulse    = miss_p_q;
  assign restart_pulse = rst_p_q;

  assign hcnt  = popcount(16'(hit_v));
  assign tcnt  = popcount(16'(tmo_v));
  assign rfall = rprev_q & ~rsync_q[SYNC_STAGES-1];

  // Grant only as many penalties as the pending score can absorb.
  always_comb begin
    if (sum[SW-1] || sum == '0) begin
      grant = '0;
    end else if (sum < $signed(SW'(tcnt))) begin
      grant = sum[4:0];
    end else begin
      grant = tcnt;
    end
  end

  always_comb begin
    dnew = (xfer ? '0 : DW2'(delta_q))
         + $signed(DW2'(hcnt)) - $signed(DW2'(grant));
    if (dnew > DMAX) begin
      dsat = DMAX;
    end else if (dnew < DMIN) begin
      dsat = DMIN;
    end else begin
      dsat = dnew;
    end
  end

  always_comb begin
    state_d    = state_q;
    delta_d    = delta_q;
    gap_d      = 1'b0;
    hold_d     = hold_q;
    hit_p_d    = 1'b0;
    miss_p_d   = 1'b0;
    rst_p_d    = 1'b0;
    restart_ok = 1'b0;
    rsync_d    = {rsync_q[SYNC_STAGES-2:0], restart_btn};
    rprev_d    = rsync_q[SYNC_STAGES-1];
    unique case (state_q)
      PLAY: begin
        delta_d  = dsat[DELTA_W-1:0];
        gap_d    = xfer;
        hit_p_d  = |hit_v;
        miss_p_d = |tmo_v;
        if (score_in >= SCORE_W'(WIN_SCORE)) begin
          state_d = OVER;
          delta_d = '0;
          gap_d   = 1'b0;
          hold_d  = '0;
        end
      end
      OVER: begin
        if (hold_q <= HO_W'(HOLDOFF)) begin
          hold_d = hold_q + HO_W'(1);
        end
        if (rfall && hold_q > HO_W'(HOLDOFF)) begin
          restart_ok = 1'b1;
          rst_p_d    = 1'b1;
          state_d    = PLAY;
          delta_d    = '0;
          hold_d     = '0;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PLAY;
      delta_q  <= '0;
      gap_q    <= 1'b0;
      hold_q   <= '0;
      hit_p_q  <= 1'b0;
      miss_p_q <= 1'b0;
      rst_p_q  <= 1'b0;
      rsync_q  <= '0;
      rprev_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      delta_q  <= delta_d;
      gap_q    <= gap_d;
      hold_q   <= hold_d;
      hit_p_q  <= hit_p_d;
      miss_p_q <= miss_p_d;
      rst_p_q  <= rst_p_d;
      rsync_q  <= rsync_d;
      rprev_q  <= rprev_d;
    end
  end

endmodule
